usb3_slfifo_rd: RTL and testbench
=================================

Name: usb3_slfifo_rd

Overview:
- Upstream stage of the channel-parameter cache.
- Drives the FX3 synchronous slave-FIFO read strobes and qualifies USB3_FLAGA.
- Reads fixed-length bursts of 32-bit words from the FX3 and presents them, with usb_rd_state and the FLAGA copy, to the RAM cache that writes the per-channel parameter RAMs.
- Owns all FX3 read timing, so the cache sees a clean word stream.

Parameters:
- BURST_LEN, 256: words read per FLAGA qualification; must be ≥ 2*RD_LATENCY.
- RD_LATENCY, 3: cycles from SLRD_N low (registered) to the matching word on data_out. FX3 contributes 2, the input register contributes 1.
- FIFO_ADDR, 2'b11: FX3 socket address driven on USB3_A during a burst.
- TURN_CYCLES, 4: idle cycles forced after a burst before FLAGA is re-sampled, covering FX3 flag update latency.

Ports:
- clk, input, 1: system clock, same clock as the FX3 PCLK.
- rst, input, 1: asynchronous, active-high reset.
- USB3_FLAGA, input, 1: FX3 "full packet available" flag, active high.
- USB3_DQ, input, 32: FX3 data bus, captured every clk into an input register.
- USB3_SLCS_N, output, 1: chip select, active low.
- USB3_SLOE_N, output, 1: output enable, active low.
- USB3_SLRD_N, output, 1: read strobe, active low.
- USB3_A, output, 2: FIFO address.
- data_out, output, 32: word to the cache.
- data_valid, output, 1: data_out holds a burst word this cycle.
- usb_rd_state, output, 4: current state code, consumed by the cache.
- flaga_q, output, 1: FLAGA registered once, forwarded to the cache as USB3_FLAGA.
- burst_done, output, 1: one-cycle pulse on the last valid word of a burst.

Behaviour:
- Reset values:
  - USB3_SLCS_N=1, USB3_SLOE_N=1, USB3_SLRD_N=1, USB3_A=FIFO_ADDR.
  - data_out=0, data_valid=0, usb_rd_state=0, flaga_q=0, burst_done=0.
  - All counters and the read pipe are 0.
- All outputs are registered.
- Reset mid-burst: state returns to IDLE and strobes deassert immediately. Words already in flight are discarded (data_valid=0). The FX3 re-presents the packet because the read was not completed.
- States, with usb_rd_state codes:
  - IDLE=0: wait for flaga_q=1, then go to QUAL.
  - QUAL=1: flaga_q=1 for 2 consecutive cycles, then go to ADDR; flaga_q=0 returns to IDLE.
  - ADDR=2: SLCS_N=0, SLOE_N=0, A=FIFO_ADDR for 1 cycle, then go to READ.
  - READ=6: SLRD_N=0. rd_cnt counts the cycles SLRD_N is low. When rd_cnt reaches BURST_LEN, deassert SLRD_N and go to DRAIN.
  - DRAIN=7: SLOE_N stays 0 for RD_LATENCY cycles to collect in-flight words, then go to TURN.
  - TURN=8: SLCS_N=1, SLOE_N=1 for TURN_CYCLES cycles, then go to IDLE.
- Read pipe:
  - A shift register of depth RD_LATENCY is loaded with the SLRD_N-active bit.
  - data_valid is the tail of the shift register; data_out is the registered USB3_DQ.
  - Exactly BURST_LEN data_valid cycles occur per burst and they are contiguous.
- burst_done asserts together with the BURST_LEN-th valid word. A 9-bit valid-word counter wraps to 0 on that word.
- FLAGA is ignored from ADDR through TURN, because a qualified flag guarantees a full packet. A FLAGA drop mid-burst therefore does not shorten the burst.
- A FLAGA glitch shorter than 2 cycles never starts a burst.
- Back-to-back packets: the minimum gap between burst_done and the next ADDR is TURN_CYCLES+3 cycles (TURN + IDLE + QUAL×2 sampling).

Optional Feature:
- Macro: USB3_RD_BACKPRESSURE_EN.
- Defined:
  - Adds input cache_full (1 bit).
  - IDLE/QUAL do not advance to ADDR while cache_full=1; usb_rd_state stays at 0 or 1.
  - A burst already past ADDR always completes, so the cache must reserve BURST_LEN words of headroom before deasserting cache_full.
- Undefined: no port is added, and bursts start on FLAGA qualification alone.

Decomposition:
- Shared package usb3_pkg holds:
  - the state codes (0, 1, 2, 6, 7, 8), also decoded by the cache;
  - the default values of BURST_LEN and FIFO_ADDR;
  - the header word constant 32'hFF00AAAA used by the cache for frame alignment.
- One sub-module is natural: usb3_rd_pipe, the parameterised RD_LATENCY shift register plus the DQ input register.

Test Plan:
- Reset, then FLAGA=1 from cycle 10 with the FX3 model returning word n=0..255:
  - SLRD_N is low for exactly 256 cycles.
  - data_valid is high for 256 contiguous cycles, with data_out=0..255 in order.
  - burst_done pulses with word 255, and usb_rd_state runs through the sequence 0,1,2,6,7,8,0.
- FLAGA pulse of 1 cycle: no state leaves 0/1, and SLCS_N stays 1.
- FLAGA drops at word 100 of a burst: all 256 words are still delivered, with no extra or missing data_valid cycle.
- FLAGA held high continuously: successive bursts are separated by ≥ TURN_CYCLES+3 cycles, and the second burst starts at word 0 with the counter wrapped.
- rst asserted at READ word 50: all outputs return to reset values within the same cycle (async). After release with FLAGA=1, a full 256-word burst follows.
- With USB3_RD_BACKPRESSURE_EN defined:
  - cache_full=1 while FLAGA=1 gives no ADDR entry; releasing cache_full starts ADDR within 2 cycles.
  - cache_full raised mid-READ does not stop the burst.

Source files
------------

// File: rtl/usb3_pkg.sv
// Shared definitions for the FX3 slave-FIFO reader and the channel-parameter cache.
// State codes are also decoded by the cache, so their values are fixed.
package usb3_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_QUAL  = 4'd1,
    ST_ADDR  = 4'd2,
    ST_READ  = 4'd6,
    ST_DRAIN = 4'd7,
    ST_TURN  = 4'd8
  } rd_state_e;

  localparam int unsigned BURST_LEN_DEF = 256;
  localparam logic [1:0]  FIFO_ADDR_DEF = 2'b11;
  localparam logic [31:0] HEADER_WORD   = 32'hFF00_AAAA;

endpackage

// File: rtl/usb3_slfifo_rd_if.sv
// FX3 synchronous slave-FIFO read-side bus; master is the FPGA reader, slave is the FX3.
interface usb3_slfifo_rd_if;

  logic        USB3_FLAGA;
  logic [31:0] USB3_DQ;
  logic        USB3_SLCS_N;
  logic        USB3_SLOE_N;
  logic        USB3_SLRD_N;
  logic [1:0]  USB3_A;

  modport master (
    input  USB3_FLAGA, USB3_DQ,
    output USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_A
  );

  modport slave (
    output USB3_FLAGA, USB3_DQ,
    input  USB3_SLCS_N, USB3_SLOE_N, USB3_SLRD_N, USB3_A
  );

endinterface

// File: rtl/usb3_rd_pipe.sv
// DQ input register plus an RD_LATENCY-deep shift register that tracks which
// captured words belong to an active read strobe. RD_LATENCY must be at least 2.
module usb3_rd_pipe #(
  parameter int RD_LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_active,
  input  logic [31:0] dq,
  output logic [31:0] data_q,
  output logic        valid_q,
  output logic        valid_next
);

  logic [RD_LATENCY-1:0] sr_q;
  logic [RD_LATENCY-1:0] sr_d;
  logic [31:0]           dq_q;

  assign sr_d[0] = rd_active;

  genvar gi;
  generate
    for (gi = 1; gi < RD_LATENCY; gi++) begin : g_sr
      assign sr_d[gi] = sr_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
      dq_q <= '0;
    end else begin
      sr_q <= sr_d;
      dq_q <= dq;
    end
  end

  assign data_q     = dq_q;
  assign valid_q    = sr_q[RD_LATENCY-1];
  // One stage early, so burst_done can be registered in step with the last word.
  assign valid_next = sr_q[RD_LATENCY-2];

endmodule

// File: rtl/usb3_slfifo_rd.sv
// FX3 slave-FIFO burst reader feeding the channel-parameter cache.
// Define USB3_RD_BACKPRESSURE_EN to add the cache_full input that holds off new bursts.
module usb3_slfifo_rd
  import usb3_pkg::*;
#(
  parameter int         BURST_LEN   = BURST_LEN_DEF,
  parameter int         RD_LATENCY  = 3,
  parameter logic [1:0] FIFO_ADDR   = FIFO_ADDR_DEF,
  parameter int         TURN_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  usb3_slfifo_rd_if.master        fx,
`ifdef USB3_RD_BACKPRESSURE_EN
  input  logic                    cache_full,
`endif
  output logic [31:0]             data_out,
  output logic                    data_valid,
  output logic [3:0]              usb_rd_state,
  output logic                    flaga_q,
  output logic                    burst_done
);

  rd_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  vcnt_q, vcnt_d;
  logic        slcs_n_q, slcs_n_d;
  logic        sloe_n_q, sloe_n_d;
  logic        slrd_n_q, slrd_n_d;
  logic [1:0]  a_q;
  logic        burst_done_q, burst_done_d;
  logic        start_ok;
  logic        valid_next;

`ifdef USB3_RD_BACKPRESSURE_EN
  assign start_ok = !cache_full;
`else
  assign start_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slcs_n_d = slcs_n_q;
    sloe_n_d = sloe_n_q;
    slrd_n_d = slrd_n_q;
    case (state_q)
      ST_IDLE: if (flaga_q) state_d = ST_QUAL;
      ST_QUAL: begin
        if (!flaga_q) begin
          state_d = ST_IDLE;
        end else if (start_ok) begin
          state_d  = ST_ADDR;
          slcs_n_d = 1'b0;
          sloe_n_d = 1'b0;
        end
      end
      ST_ADDR: begin
        state_d  = ST_READ;
        slrd_n_d = 1'b0;
        cnt_d    = '0;
      end
      // cnt counts strobe-low cycles; FLAGA is deliberately ignored from here on.
      ST_READ: begin
        if (cnt_q == 16'(BURST_LEN - 1)) begin
          state_d  = ST_DRAIN;
          slrd_n_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == 16'(RD_LATENCY - 1)) begin
          state_d  = ST_TURN;
          slcs_n_d = 1'b1;
          sloe_n_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_TURN: begin
        if (cnt_q == 16'(TURN_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        slcs_n_d = 1'b1;
        sloe_n_d = 1'b1;
        slrd_n_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    vcnt_d       = vcnt_q;
    burst_done_d = 1'b0;
    if (valid_next) begin
      if (vcnt_q == 9'(BURST_LEN - 1)) begin
        vcnt_d       = '0;
        burst_done_d = 1'b1;
      end else begin
        vcnt_d = vcnt_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vcnt_q       <= '0;
      slcs_n_q     <= 1'b1;
      sloe_n_q     <= 1'b1;
      slrd_n_q     <= 1'b1;
      a_q          <= FIFO_ADDR;
      flaga_q      <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vcnt_q       <= vcnt_d;
      slcs_n_q     <= slcs_n_d;
      sloe_n_q     <= sloe_n_d;
      slrd_n_q     <= slrd_n_d;
      a_q          <= FIFO_ADDR;
      flaga_q      <= fx.USB3_FLAGA;
      burst_done_q <= burst_done_d;
    end
  end

  usb3_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .rd_active  (!slrd_n_q),
    .dq         (fx.USB3_DQ),
    .data_q     (data_out),
    .valid_q    (data_valid),
    .valid_next (valid_next)
  );

  assign fx.USB3_SLCS_N = slcs_n_q;
  assign fx.USB3_SLOE_N = sloe_n_q;
  assign fx.USB3_SLRD_N = slrd_n_q;
  assign fx.USB3_A      = a_q;
  assign usb_rd_state   = state_q;
  assign burst_done     = burst_done_q;

endmodule

// File: tb/tb_usb3_slfifo_rd.sv
// Directed bench for usb3_slfifo_rd with a 2-cycle-latency FX3 read model.
module tb_usb3_slfifo_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_out;
  logic        data_valid;
  logic [3:0]  usb_rd_state;
  logic        flaga_q;
  logic        burst_done;
`ifdef USB3_RD_BACKPRESSURE_EN
  logic        cache_full = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  usb3_slfifo_rd_if fx();

  usb3_slfifo_rd dut (
    .clk          (clk),
    .rst          (rst),
    .fx           (fx),
`ifdef USB3_RD_BACKPRESSURE_EN
    .cache_full   (cache_full),
`endif
    .data_out     (data_out),
    .data_valid   (data_valid),
    .usb_rd_state (usb_rd_state),
    .flaga_q      (flaga_q),
    .burst_done   (burst_done)
  );

  always #5 clk = ~clk;

  // FX3 model: a word appears on DQ two cycles after a cycle with SLRD_N and SLCS_N low.
  logic [1:0] fx_hist;
  logic [7:0] fx_idx;
  initial begin
    fx.USB3_FLAGA = 1'b0;
    fx.USB3_DQ    = 32'h0;
    fx_hist       = 2'b00;
    fx_idx        = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        fx_hist    = 2'b00;
        fx_idx     = 8'h00;
        fx.USB3_DQ = 32'h0;
      end else begin
        if (fx_hist[1]) begin
          fx.USB3_DQ = {24'h0, fx_idx};
          fx_idx     = fx_idx + 8'd1;
        end else begin
          fx.USB3_DQ = 32'hDEAD_BEEF;
        end
        fx_hist = {fx_hist[0], (!fx.USB3_SLRD_N && !fx.USB3_SLCS_N)};
      end
    end
  end

  // Observation counters sampled 1 ns after each rising edge.
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         n_slrd, n_slcs_low, n_valid, n_runs, n_bad, n_done, n_done_bad;
  int         n_nonqual, n_addr, gap_min, last_done_cyc;
  bit         have_done, prev_valid;
  logic [7:0] exp_word;
  logic [3:0] last_st;
  logic [3:0] st_seq[$];

  task automatic clear_mon();
    n_slrd = 0; n_slcs_low = 0; n_valid = 0; n_runs = 0; n_bad = 0;
    n_done = 0; n_done_bad = 0; n_nonqual = 0; n_addr = 0;
    gap_min = 1000000; last_done_cyc = 0; have_done = 1'b0;
    prev_valid = 1'b0; exp_word = 8'h00; last_st = 4'hF;
    st_seq.delete();
  endtask

  initial begin
    clear_mon();
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        if (fx.USB3_SLRD_N === 1'b0) n_slrd++;
        if (fx.USB3_SLCS_N === 1'b0) n_slcs_low++;
        if (usb_rd_state !== 4'd0 && usb_rd_state !== 4'd1) n_nonqual++;
        if (data_valid === 1'b1) begin
          n_valid++;
          if (!prev_valid) n_runs++;
          if (data_out !== {24'h0, exp_word}) n_bad++;
          exp_word = exp_word + 8'd1;
        end
        prev_valid = (data_valid === 1'b1);
        if (burst_done === 1'b1) begin
          n_done++;
          if (data_valid !== 1'b1 || data_out[7:0] !== 8'hFF) n_done_bad++;
          last_done_cyc = cyc;
          have_done     = 1'b1;
        end
        if (usb_rd_state !== last_st) begin
          st_seq.push_back(usb_rd_state);
          if (usb_rd_state === 4'd2) begin
            n_addr++;
            if (have_done && (cyc - last_done_cyc) < gap_min) gap_min = cyc - last_done_cyc;
          end
        end
        last_st = usb_rd_state;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks += 9;
    if (fx.USB3_SLCS_N !== 1'b1) begin n_fail++; $display("FAIL %s slcs_n: got %b expected 1", tag, fx.USB3_SLCS_N); end
    if (fx.USB3_SLOE_N !== 1'b1) begin n_fail++; $display("FAIL %s sloe_n: got %b expected 1", tag, fx.USB3_SLOE_N); end
    if (fx.USB3_SLRD_N !== 1'b1) begin n_fail++; $display("FAIL %s slrd_n: got %b expected 1", tag, fx.USB3_SLRD_N); end
    if (fx.USB3_A !== 2'b11) begin n_fail++; $display("FAIL %s addr: got %b expected 11", tag, fx.USB3_A); end
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL %s data_out: got %h expected 0", tag, data_out); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL %s data_valid: got %b expected 0", tag, data_valid); end
    if (usb_rd_state !== 4'd0) begin n_fail++; $display("FAIL %s state: got %0d expected 0", tag, usb_rd_state); end
    if (flaga_q !== 1'b0) begin n_fail++; $display("FAIL %s flaga_q: got %b expected 0", tag, flaga_q); end
    if (burst_done !== 1'b0) begin n_fail++; $display("FAIL %s burst_done: got %b expected 0", tag, burst_done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fx.USB3_FLAGA = 1'b1;
    tick(4);
    check_reset_outputs("reset");
    fx.USB3_FLAGA = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    if (usb_rd_state !== 4'd0) begin n_fail++; $display("FAIL reset_idle: got %0d expected 0", usb_rd_state); end
    n_checks++;
    $display("test_reset done");
  endtask

  task automatic test_single_burst();
    logic [3:0] exp_seq[7];
    bit seq_ok;
    exp_seq = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd0};
    clear_mon();
    mon_en = 1'b1;
    tick(10);
    fx.USB3_FLAGA = 1'b1;
    for (int i = 0; i < 20 && usb_rd_state !== 4'd6; i++) tick(1);
    fx.USB3_FLAGA = 1'b0;
    for (int i = 0; i < 400 && n_done < 1; i++) tick(1);
    tick(12);
    chk("single_slrd_low", n_slrd, 256);
    chk("single_valid", n_valid, 256);
    chk("single_runs", n_runs, 1);
    chk("single_bad_words", n_bad, 0);
    chk("single_done", n_done, 1);
    chk("single_done_align", n_done_bad, 0);
    seq_ok = (st_seq.size() == 7);
    for (int i = 0; i < 7 && seq_ok; i++) if (st_seq[i] !== exp_seq[i]) seq_ok = 1'b0;
    n_checks++;
    if (!seq_ok) begin
      n_fail++;
      $display("FAIL single_state_seq: got %p expected 0,1,2,6,7,8,0", st_seq);
    end
    $display("test_single_burst done: %0d words", n_valid);
  endtask

  task automatic test_flaga_glitch();
    clear_mon();
    tick(2);
    fx.USB3_FLAGA = 1'b1;
    tick(1);
    fx.USB3_FLAGA = 1'b0;
    tick(20);
    chk("glitch_left_qual", n_nonqual, 0);
    chk("glitch_slcs_low", n_slcs_low, 0);
    chk("glitch_slrd_low", n_slrd, 0);
    $display("test_flaga_glitch done");
  endtask

  task automatic test_flaga_drop();
    clear_mon();
    fx.USB3_FLAGA = 1'b1;
    for (int i = 0; i < 400 && n_valid < 100; i++) tick(1);
    fx.USB3_FLAGA = 1'b0;
    for (int i = 0; i < 400 && n_done < 1; i++) tick(1);
    tick(12);
    chk("drop_valid", n_valid, 256);
    chk("drop_runs", n_runs, 1);
    chk("drop_bad_words", n_bad, 0);
    chk("drop_done", n_done, 1);
    chk("drop_idle", usb_rd_state, 0);
    $display("test_flaga_drop done: %0d words", n_valid);
  endtask

  task automatic test_back_to_back();
    clear_mon();
    fx.USB3_FLAGA = 1'b1;
    for (int i = 0; i < 1200 && n_done < 2; i++) tick(1);
    fx.USB3_FLAGA = 1'b0;
    tick(15);
    chk("b2b_done", n_done, 2);
    chk("b2b_valid", n_valid, 512);
    chk("b2b_runs", n_runs, 2);
    chk("b2b_bad_words", n_bad, 0);
    chk("b2b_done_align", n_done_bad, 0);
    chk("b2b_addr", n_addr, 2);
    n_checks++;
    if (gap_min < 7) begin
      n_fail++;
      $display("FAIL b2b_gap: got %0d expected >= 7", gap_min);
    end
    $display("test_back_to_back done: gap %0d", gap_min);
  endtask

  task automatic test_reset_mid_burst();
    clear_mon();
    fx.USB3_FLAGA = 1'b1;
    for (int i = 0; i < 400 && n_valid < 50; i++) tick(1);
    chk("midrst_reached_word50", n_valid, 50);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    clear_mon();
    mon_en = 1'b1;
    for (int i = 0; i < 500 && n_done < 1; i++) tick(1);
    fx.USB3_FLAGA = 1'b0;
    tick(12);
    chk("midrst_valid", n_valid, 256);
    chk("midrst_runs", n_runs, 1);
    chk("midrst_bad_words", n_bad, 0);
    chk("midrst_done", n_done, 1);
    $display("test_reset_mid_burst done: %0d words", n_valid);
  endtask

`ifdef USB3_RD_BACKPRESSURE_EN
  task automatic test_backpressure();
    int k;
    clear_mon();
    cache_full    = 1'b1;
    fx.USB3_FLAGA = 1'b1;
    tick(20);
    chk("bp_no_addr", n_nonqual, 0);
    chk("bp_held_qual", usb_rd_state, 1);
    cache_full = 1'b0;
    k = 0;
    while (k < 10 && usb_rd_state !== 4'd2) begin
      @(posedge clk);
      #1;
      k++;
    end
    #1;
    n_checks++;
    if (k > 2) begin
      n_fail++;
      $display("FAIL bp_release_latency: got %0d cycles expected <= 2", k);
    end
    for (int i = 0; i < 400 && n_valid < 50; i++) tick(1);
    cache_full    = 1'b1;
    fx.USB3_FLAGA = 1'b0;
    for (int i = 0; i < 400 && n_done < 1; i++) tick(1);
    tick(12);
    chk("bp_mid_valid", n_valid, 256);
    chk("bp_mid_done", n_done, 1);
    chk("bp_mid_bad_words", n_bad, 0);
    cache_full = 1'b0;
    $display("test_backpressure done: release latency %0d", k);
  endtask
`endif

  initial begin
    test_reset();
    test_single_burst();
    test_flaga_glitch();
    test_flaga_drop();
    test_back_to_back();
    test_reset_mid_burst();
`ifdef USB3_RD_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
